// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and width helper for the round-robin hold arbiter
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request bit at or after ptr, wrapping past N-1 back to 0
module rr_pick import arb_pkg::*; #(
  parameter int N = 2,
  localparam int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] sel
);
  always_comb begin
    valid = 1'b0;
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        valid = 1'b1;
        sel = IDW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin arbiter with hold budget and a forced idle cycle on every handover
module rr_hold_arbiter import arb_pkg::*; #(
  parameter int N = 2,
  parameter int MAX_HOLD = 4,
  localparam int IDW = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   request,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy
);
  localparam int HW = clog2_min1(MAX_HOLD + 1);
  arb_state_e state, state_nx;
  logic [IDW-1:0] ptr, ptr_nx, id_nx, sel;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [N-1:0] grant_nx;
  logic busy_nx, valid, hold_sat, preempt, leave;
  rr_pick #(.N(N)) u_pick (.req(request), .ptr(ptr), .valid(valid), .sel(sel));
  assign hold_sat = (MAX_HOLD == 0) || (hold_cnt == HW'(MAX_HOLD));
  assign preempt = (MAX_HOLD != 0) && hold_sat && |(request & ~grant);
  assign leave = !request[grant_id] || preempt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      grant <= '0;
      grant_id <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      hold_cnt <= hold_nx;
      grant <= grant_nx;
      grant_id <= id_nx;
      busy <= busy_nx;
    end
  end
  always_comb begin
    state_nx = (state == ARB_IDLE) ? (valid ? ARB_GRANT : ARB_IDLE)
                                   : (leave ? ARB_IDLE : ARB_GRANT);
  end
  // Registered outputs are computed here as next values so nothing reaches grant combinationally
  always_comb begin
    ptr_nx = ptr;
    hold_nx = hold_cnt;
    grant_nx = grant;
    id_nx = grant_id;
    busy_nx = busy;
    if (state == ARB_IDLE && valid) begin
      grant_nx = '0;
      grant_nx[sel] = 1'b1;
      id_nx = sel;
      hold_nx = HW'(1);
      busy_nx = 1'b1;
    end else if (state == ARB_GRANT && leave) begin
      grant_nx = '0;
      id_nx = '0;
      busy_nx = 1'b0;
      ptr_nx = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
    end else if (state == ARB_GRANT) begin
      hold_nx = hold_sat ? hold_cnt : hold_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: directed checks of two arbiter configurations and the standalone picker
module tb_rr_hold_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req2, g2;
  logic id2, b2;
  logic [3:0] req4, g4, p_req;
  logic [1:0] id4, p_ptr, p_sel;
  logic b4, p_valid;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rr_hold_arbiter #(.N(2), .MAX_HOLD(4)) u2 (.clk(clk), .reset(reset), .request(req2),
    .grant(g2), .grant_id(id2), .busy(b2));
  rr_hold_arbiter #(.N(4), .MAX_HOLD(0)) u4 (.clk(clk), .reset(reset), .request(req4),
    .grant(g4), .grant_id(id4), .busy(b4));
  rr_pick #(.N(4)) u_pick (.req(p_req), .ptr(p_ptr), .valid(p_valid), .sel(p_sel));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk2(input string tag, input logic [1:0] eg, input logic eid);
    chk({tag, ".grant"}, 32'(g2), 32'(eg));
    chk({tag, ".id"}, 32'(id2), 32'(eid));
    chk({tag, ".busy"}, 32'(b2), 32'(eg != 2'b00));
  endtask
  task automatic chk4(input string tag, input logic [3:0] eg, input logic [1:0] eid);
    chk({tag, ".grant"}, 32'(g4), 32'(eg));
    chk({tag, ".id"}, 32'(id4), 32'(eid));
    chk({tag, ".busy"}, 32'(b4), 32'(eg != 4'b0000));
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  initial begin
    reset = 1'b1;
    req2 = 2'b00;
    req4 = 4'b0000;
    p_req = 4'b0000;
    p_ptr = 2'd0;
    #5 reset = 1'b0;
    #1 chk2("reset", 2'b00, 1'b0);
    chk4("reset4", 4'b0000, 2'd0);
    repeat (3) begin
      tick;
      chk2("idle", 2'b00, 1'b0);
    end
    req2 = 2'b11;
    repeat (4) begin
      tick;
      chk2("dual.own0", 2'b01, 1'b0);
    end
    tick;
    chk2("dual.gap0", 2'b00, 1'b0);
    repeat (4) begin
      tick;
      chk2("dual.own1", 2'b10, 1'b1);
    end
    tick;
    chk2("dual.gap1", 2'b00, 1'b0);
    tick;
    chk2("dual.back0", 2'b01, 1'b0);
    req2 = 2'b00;
    tick;
    chk2("dual.drop", 2'b00, 1'b0);
    tick;
    chk2("dual.idle", 2'b00, 1'b0);
    req2 = 2'b10;
    repeat (20) begin
      tick;
      chk2("sole", 2'b10, 1'b1);
    end
    req2 = 2'b00;
    tick;
    chk2("sole.drop", 2'b00, 1'b0);
    req2 = 2'b11;
    tick;
    chk2("vol.own0a", 2'b01, 1'b0);
    tick;
    chk2("vol.own0b", 2'b01, 1'b0);
    req2 = 2'b10;
    tick;
    chk2("vol.gap", 2'b00, 1'b0);
    tick;
    chk2("vol.own1", 2'b10, 1'b1);
    #3 reset = 1'b1;
    #1 chk2("async", 2'b00, 1'b0);
    req2 = 2'b11;
    #1 reset = 1'b0;
    tick;
    chk2("post_reset", 2'b01, 1'b0);
    req2 = 2'b00;
    req4 = 4'b1111;
    repeat (50) begin
      tick;
      chk4("nolimit", 4'b0001, 2'd0);
    end
    req4 = 4'b1110;
    tick;
    chk4("nolimit.drop", 4'b0000, 2'd0);
    tick;
    chk4("nolimit.next", 4'b0010, 2'd1);
    req4 = 4'b0001;
    tick;
    chk4("wrap.gap", 4'b0000, 2'd0);
    tick;
    chk4("wrap.own0", 4'b0001, 2'd0);
    p_req = 4'b0101; p_ptr = 2'd1;
    #1 chk("pick.fwd", {p_valid, 2'(p_sel)}, {1'b1, 2'd2});
    p_ptr = 2'd3;
    #1 chk("pick.wrap", {p_valid, 2'(p_sel)}, {1'b1, 2'd0});
    p_req = 4'b1000; p_ptr = 2'd0;
    #1 chk("pick.top", {p_valid, 2'(p_sel)}, {1'b1, 2'd3});
    p_req = 4'b0100; p_ptr = 2'd2;
    #1 chk("pick.self", {p_valid, 2'(p_sel)}, {1'b1, 2'd2});
    p_req = 4'b0000;
    #1 chk("pick.none", 32'(p_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
